// File: rtl/dm_pkg.sv
// Shared types and default parameters for the accumulator computer data memory.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dm_pkg;

    localparam int DM_MODE_W          = 2;
    localparam int DM_DATA_W_DEF      = 8;
    localparam int DM_ADDR_W_DEF      = 8;
    localparam int DM_STACK_LIMIT_DEF = 128;

    typedef enum logic [DM_MODE_W-1:0] {
        DM_DIR  = 2'b00,
        DM_IND  = 2'b01,
        DM_PUSH = 2'b10,
        DM_POP  = 2'b11
    } dm_mode_e;

endpackage

// File: rtl/dm_stack_ptr.sv
// Stack pointer for the data memory: grows downward, SP names the next free slot.
// Latency: SP and flags update on the rising edge; sp_inc/push_ok/pop_blk are combinational from SP.
// Backpressure: none; with DM_STACK_CHECK_EN a full push / empty pop is dropped and flagged sticky.
module dm_stack_ptr #(
    parameter int ADDR_W      = 8,
    parameter int STACK_BASE  = 2**ADDR_W - 1,
    parameter int STACK_LIMIT = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] sp_inc,
    output logic              push_ok,
    output logic              pop_blk,
    output logic              ovf,
    output logic              unf
);

    localparam logic [ADDR_W-1:0] EMPTY_SP = ADDR_W'(STACK_BASE);

    logic [ADDR_W-1:0] sp_q, sp_d;
    logic              pop_ok;

    assign sp     = sp_q;
    assign sp_inc = sp_q + ADDR_W'(1);

`ifdef DM_STACK_CHECK_EN
    localparam logic [ADDR_W-1:0] FULL_SP = ADDR_W'(STACK_LIMIT - 1);

    logic full, empty;
    logic ovf_q, ovf_d, unf_q, unf_d;

    // Guard the stack bounds and accumulate the sticky error flags.
    always_comb begin
        full    = (sp_q == FULL_SP);
        empty   = (sp_q == EMPTY_SP);
        push_ok = push & ~full;
        pop_ok  = pop & ~empty;
        pop_blk = pop & empty;
        ovf_d   = ovf_q | (push & full);
        unf_d   = unf_q | (pop & empty);
    end

    // Sticky flags clear only on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;
`else
    // Unchecked build: every push/pop moves SP, wrapping modulo 2**ADDR_W.
    always_comb begin
        push_ok = push;
        pop_ok  = pop;
        pop_blk = 1'b0;
    end

    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

    // Next SP: down on an accepted push, up on an accepted pop.
    always_comb begin
        sp_d = sp_q;
        if (push_ok) begin
            sp_d = sp_q - ADDR_W'(1);
        end else if (pop_ok) begin
            sp_d = sp_inc;
        end
    end

    // SP register, reset to the top of the stack region.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= EMPTY_SP;
        end else begin
            sp_q <= sp_d;
        end
    end

endmodule

// File: rtl/data_memory_stack.sv
// Data memory with direct, indirect and hardware-stack (PUSH/POP) access; optional bound checks via DM_STACK_CHECK_EN.
// Latency: reads are combinational (0 cycles, no write bypass); writes and SP updates take effect at the rising edge.
// Backpressure: none, one access per clock; en qualifies PUSH/POP only, we qualifies DIR/IND writes only.
module data_memory_stack
    import dm_pkg::*;
#(
    parameter int DATA_W      = DM_DATA_W_DEF,
    parameter int ADDR_W      = DM_ADDR_W_DEF,
    parameter int STACK_BASE  = 2**ADDR_W - 1,
    parameter int STACK_LIMIT = DM_STACK_LIMIT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [DM_MODE_W-1:0] mode,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    dir,
    input  logic [ADDR_W-1:0]    ind,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata,
    output logic [ADDR_W-1:0]    sp,
    output logic                 ovf,
    output logic                 unf
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    dm_mode_e          mode_e;
    logic              push, pop, push_ok, pop_blk;
    logic [ADDR_W-1:0] sp_inc;
    logic [ADDR_W-1:0] acc_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_dat;

    assign mode_e = dm_mode_e'(mode);
    assign push   = en & (mode_e == DM_PUSH);
    assign pop    = en & (mode_e == DM_POP);

    dm_stack_ptr #(
        .ADDR_W      (ADDR_W),
        .STACK_BASE  (STACK_BASE),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_sp (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .sp      (sp),
        .sp_inc  (sp_inc),
        .push_ok (push_ok),
        .pop_blk (pop_blk),
        .ovf     (ovf),
        .unf     (unf)
    );

    // Select the access address and the single write port's controls.
    always_comb begin
        acc_addr = (mode_e == DM_IND) ? ind : dir;
        wr_en    = 1'b0;
        wr_addr  = acc_addr;
        wr_dat   = wdata;
        case (mode_e)
            DM_DIR, DM_IND: wr_en = we;
            DM_PUSH: begin
                wr_en   = push_ok;
                wr_addr = sp;
            end
            default: wr_en = 1'b0;
        endcase
    end

    // Read mux: addressed word for DIR/IND, top of stack otherwise; a blocked pop reads zero.
    always_comb begin
        rdata = '0;
        case (mode_e)
            DM_DIR, DM_IND: rdata = mem[acc_addr];
            default:        rdata = pop_blk ? '0 : mem[sp_inc];
        endcase
    end

    // Storage array; reset clears every word so an aborted access leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

endmodule
